fx_kport: RTL

FX_KPORT -- requirements
Module: fx_kport

---
 rtl/fx_kport_pkg.sv | 24 ++
 rtl/fx_kport_tick.sv | 28 ++
 rtl/fx_kport.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fx_kport_pkg.sv
// Shared types and constants for the fx_kport serial pad port.
// Holds the state encoding, frame lengths and idle pad levels.
package fx_kport_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] BITS_LONG  = 6'd32;
  localparam logic [5:0] BITS_SHORT = 6'd16;

  localparam logic KP_CLK_IDLE   = 1'b1;
  localparam logic KP_DO_IDLE    = 1'b1;
  localparam logic KP_LATCH_IDLE = 1'b0;

  function automatic logic [5:0] frame_bits(input logic mod);
    return mod ? BITS_LONG : BITS_SHORT;
  endfunction

endpackage

// File: rtl/fx_kport_tick.sv
// CE-gated half-period divider: strobes last on the final CE cycle of each phase.
// The count restarts whenever run is low, so every phase begins from zero.
module fx_kport_tick #(
  parameter int HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic run,
  output logic last
);

  localparam logic [7:0] TOP = 8'(HALF - 1);

  logic [7:0] cnt_reg;

  assign last = run && (cnt_reg == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (ce) begin
      if (!run || last) cnt_reg <= '0;
      else              cnt_reg <= cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/fx_kport.sv
// K-port serial controller: latch strobe, then N clocked bits, full-duplex or receive-only.
// Outputs are registered from the next-state values so they line up with the state register.
module fx_kport
  import fx_kport_pkg::*;
#(
  parameter int HALF = 8
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        TRG,
  input  logic        MOD,
  input  logic        IOS,
  input  logic [31:0] TXD,
  output logic [31:0] RXD,
  output logic        BUSY,
  output logic        END,
  output logic        KP_LATCH,
  output logic        KP_CLK,
  output logic        KP_DO,
  input  logic        KP_DI
);

  state_t      state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [5:0]  bits_reg, bits_next;
  logic        mod_reg, mod_next;
  logic        ios_reg, ios_next;
  logic [31:0] rxd_reg, rxd_next;
  logic        busy_reg, busy_next;
  logic        end_reg, end_next;
  logic        latch_reg, latch_next;
  logic        kclk_reg, kclk_next;
  logic        kdo_reg, kdo_next;
  logic        di_meta_reg, di_sync_reg;
  logic        run;
  logic        last;

  assign run = (state_reg == ST_LATCH) || (state_reg == ST_LOW) || (state_reg == ST_HIGH);

  fx_kport_tick #(.HALF(HALF)) u_tick (
    .clk  (CLK),
    .rst_n(RESn),
    .ce   (CE),
    .run  (run),
    .last (last)
  );

  // Pad input is asynchronous: resynchronise on every clock, regardless of CE.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      di_meta_reg <= 1'b0;
      di_sync_reg <= 1'b0;
    end else begin
      di_meta_reg <= KP_DI;
      di_sync_reg <= di_meta_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bits_next  = bits_reg;
    mod_next   = mod_reg;
    ios_next   = ios_reg;
    rxd_next   = rxd_reg;
    case (state_reg)
      ST_IDLE: begin
        if (TRG) begin
          shift_next = TXD;
          bits_next  = frame_bits(MOD);
          mod_next   = MOD;
          ios_next   = IOS;
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: if (last) state_next = ST_LOW;
      ST_LOW:   if (last) state_next = ST_HIGH;
      ST_HIGH: begin
        if (last) begin
          shift_next = {di_sync_reg, shift_reg[31:1]};
          bits_next  = bits_reg - 6'd1;
          if (bits_reg == 6'd1) begin
            // Capture the word on entry to DONE so RXD is valid alongside END.
            rxd_next   = mod_reg ? shift_next : {16'h0000, shift_next[31:16]};
            state_next = ST_DONE;
          end else begin
            state_next = ST_LOW;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    busy_next  = (state_next != ST_IDLE);
    end_next   = (state_next == ST_DONE);
    latch_next = (state_next == ST_LATCH) ? 1'b1 : KP_LATCH_IDLE;
    kclk_next  = (state_next == ST_LOW) ? 1'b0 : KP_CLK_IDLE;
    kdo_next   = KP_DO_IDLE;
    if (((state_next == ST_LOW) || (state_next == ST_HIGH)) && !ios_next)
      kdo_next = shift_next[0];
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      bits_reg  <= '0;
      mod_reg   <= 1'b0;
      ios_reg   <= 1'b0;
      rxd_reg   <= '0;
      busy_reg  <= 1'b0;
      end_reg   <= 1'b0;
      latch_reg <= KP_LATCH_IDLE;
      kclk_reg  <= KP_CLK_IDLE;
      kdo_reg   <= KP_DO_IDLE;
    end else if (CE) begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bits_reg  <= bits_next;
      mod_reg   <= mod_next;
      ios_reg   <= ios_next;
      rxd_reg   <= rxd_next;
      busy_reg  <= busy_next;
      end_reg   <= end_next;
      latch_reg <= latch_next;
      kclk_reg  <= kclk_next;
      kdo_reg   <= kdo_next;
    end
  end

  assign RXD      = rxd_reg;
  assign BUSY     = busy_reg;
  assign END      = end_reg;
  assign KP_LATCH = latch_reg;
  assign KP_CLK   = kclk_reg;
  assign KP_DO    = kdo_reg;

endmodule
